ldpc_enc_ctrl_par: RTL and testbench
====================================

LDPC_ENC_CTRL_PAR -- requirements
Module: ldpc_enc_ctrl_par

Interface
REQ-001 Parameter CNT_W, default 8: width of the beat counters and length fields.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a codeword; sampled only in IDLE.
REQ-005 info_beats  input  CNT_W  number of message beats per codeword; latched at an accepted start.
REQ-006 par_beats  input  CNT_W  number of parity beats per codeword; latched at an accepted start.
REQ-007 din_valid  input  1  message beat present.
REQ-008 din_ready  output  1  block accepts a message beat this cycle.
REQ-009 read_parity  input  1  request to drain parity; sampled only in HOLD.
REQ-010 parity_ready  input  1  downstream accepts a parity beat.
REQ-011 parity_valid  output  1  parity beat presented this cycle.
REQ-012 abort  input  1  synchronous abandon of the current codeword.
REQ-013 rom_addr  output  CNT_W  registered generator-ROM beat index (message beat count).
REQ-014 out_addr  output  CNT_W  registered parity beat index.
REQ-015 en_G, load_g, en_L, en_out  output  1 each  generator-register enable, generator preload, LFSR/accumulator enable, parity-output enable.
REQ-016 done_encode  output  1  parity complete and waiting to be read.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 rst_c  output  1  active-low clear for the datapath accumulators.
REQ-019 err_len  output  1  one-cycle pulse on a rejected start.

Function
REQ-020 The block SHALL implement four states: IDLE, ENCODE, HOLD and OUT.
REQ-021 The strobes en_G, load_g, en_L, en_out, din_ready, parity_valid, done_encode, rst_c and err_len SHALL be combinational decodes of the current state and inputs (Mealy); the state, counters and latched lengths SHALL be registered.
REQ-022 Default strobe values SHALL be: all 0, except rst_c = 1.
REQ-023 In IDLE, start=1 with both lengths nonzero SHALL drive load_g=1 and en_G=1 that cycle, latch both lengths, clear rom_addr and out_addr, and move to ENCODE.
REQ-024 In IDLE, start=1 with either length equal to 0 SHALL pulse err_len for one cycle and remain in IDLE.
REQ-025 In ENCODE, din_ready SHALL be 1.
REQ-026 In ENCODE, each handshake (din_valid & din_ready) SHALL drive en_L=1 and en_G=1 that cycle and increment rom_addr.
REQ-027 In ENCODE, the handshake occurring at rom_addr == info_beats-1 SHALL move the block to HOLD, with rom_addr wrapping to 0.
REQ-028 In ENCODE, when no handshake occurs, en_L and en_G SHALL be 0 and the state SHALL hold.
REQ-029 In HOLD, done_encode SHALL be 1 and din_ready SHALL be 0.
REQ-030 In HOLD, read_parity=1 SHALL move the block to OUT with out_addr=0; otherwise the block SHALL remain in HOLD.
REQ-031 In OUT, parity_valid SHALL be 1.
REQ-032 In OUT, en_out SHALL equal parity_valid & parity_ready, and each such handshake SHALL increment out_addr.
REQ-033 In OUT, when parity_ready=0, out_addr and the state SHALL hold; no beat is lost or repeated.
REQ-034 In OUT, the handshake at out_addr == par_beats-1 SHALL drive rst_c=0 that cycle, clear out_addr, and move the block to IDLE.
REQ-035 abort=1 in ENCODE, HOLD or OUT SHALL have priority over all other inputs: drive rst_c=0 that cycle, suppress en_L, en_G and en_out, clear both counters, and move to IDLE.
REQ-036 abort in IDLE SHALL be ignored; start and abort together in IDLE SHALL treat start normally.
REQ-037 Counter arithmetic SHALL be unsigned CNT_W modulo; length value 2^CNT_W-1 SHALL be supported; latched lengths SHALL NOT change mid-codeword.
REQ-038 A new start SHALL be accepted the cycle after the return to IDLE (back-to-back codewords).

Reset
REQ-039 While rst_n=0: state=IDLE, rom_addr=0, out_addr=0, latched lengths=0, busy=0, din_ready=0, parity_valid=0, done_encode=0, rst_c=1, all enables 0.
REQ-040 Reset asserted mid-operation SHALL take effect immediately, regardless of the clock.
REQ-041 The first cycle after rst_n deasserts SHALL behave as IDLE.

Verification
REQ-042 Nominal: start with info_beats=4, par_beats=3; din_valid continuous -> load_g on the start cycle; en_L on 4 cycles with rom_addr 0..3; HOLD; read_parity -> 3 en_out beats with out_addr 0..2; rst_c low on the last beat; back in IDLE.
REQ-043 Backpressure: in OUT, toggle parity_ready 1,0,0,1,1 with par_beats=3 -> en_out only on ready cycles; out_addr holds during stalls; exactly 3 beats transferred.
REQ-044 Input gaps: info_beats=3 with din_valid 1,0,1,0,1 -> rom_addr advances only on valid cycles; HOLD entered after the 3rd handshake.
REQ-045 Abort: abort at rom_addr=2 in ENCODE, and separately in OUT -> rst_c=0 for one cycle, counters 0, IDLE next cycle, no en_out on the abort cycle.
REQ-046 Bad length: start with info_beats=0 -> err_len pulses for one cycle, busy stays 0; start with par_beats=255 -> accepted, and 255 parity beats are drained.
REQ-047 Async reset: rst_n low mid-OUT between clock edges -> outputs take reset values immediately; a start after release runs a full codeword.

Source files
------------

// File: rtl/ldpc_enc_ctrl_par.sv
// LDPC encoder control: sequences message intake, parity hold and parity drain.
// Strobes are Mealy decodes of state and inputs; state, counters and lengths are registered.
module ldpc_enc_ctrl_par #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] info_beats,
    input  logic [CNT_W-1:0] par_beats,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             read_parity,
    input  logic             parity_ready,
    output logic             parity_valid,
    input  logic             abort,
    output logic [CNT_W-1:0] rom_addr,
    output logic [CNT_W-1:0] out_addr,
    output logic             en_G,
    output logic             load_g,
    output logic             en_L,
    output logic             en_out,
    output logic             done_encode,
    output logic             busy,
    output logic             rst_c,
    output logic             err_len
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENCODE,
        S_HOLD,
        S_OUT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rom_addr_q, rom_addr_d;
    logic [CNT_W-1:0] out_addr_q, out_addr_d;
    logic [CNT_W-1:0] info_q, info_d;
    logic [CNT_W-1:0] par_q, par_d;

    logic len_ok;
    logic last_in;
    logic last_out;

    assign len_ok   = (|info_beats) && (|par_beats);
    assign last_in  = (rom_addr_q == info_q - CNT_W'(1));
    assign last_out = (out_addr_q == par_q - CNT_W'(1));

    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        out_addr_d   = out_addr_q;
        info_d       = info_q;
        par_d        = par_q;
        en_G         = 1'b0;
        load_g       = 1'b0;
        en_L         = 1'b0;
        en_out       = 1'b0;
        din_ready    = 1'b0;
        parity_valid = 1'b0;
        done_encode  = 1'b0;
        rst_c        = 1'b1;
        err_len      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && len_ok) begin
                    load_g     = 1'b1;
                    en_G       = 1'b1;
                    info_d     = info_beats;
                    par_d      = par_beats;
                    rom_addr_d = '0;
                    out_addr_d = '0;
                    state_d    = S_ENCODE;
                end else if (start) begin
                    err_len = 1'b1;
                end
            end
            S_ENCODE: begin
                din_ready = 1'b1;
                if (abort) begin
                    rst_c      = 1'b0;
                    rom_addr_d = '0;
                    out_addr_d = '0;
                    state_d    = S_IDLE;
                end else if (din_valid) begin
                    en_L = 1'b1;
                    en_G = 1'b1;
                    if (last_in) begin
                        rom_addr_d = '0;
                        state_d    = S_HOLD;
                    end else begin
                        rom_addr_d = rom_addr_q + CNT_W'(1);
                    end
                end
            end
            S_HOLD: begin
                done_encode = 1'b1;
                if (abort) begin
                    rst_c      = 1'b0;
                    rom_addr_d = '0;
                    out_addr_d = '0;
                    state_d    = S_IDLE;
                end else if (read_parity) begin
                    out_addr_d = '0;
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                parity_valid = 1'b1;
                if (abort) begin
                    rst_c      = 1'b0;
                    rom_addr_d = '0;
                    out_addr_d = '0;
                    state_d    = S_IDLE;
                end else if (parity_ready) begin
                    en_out = 1'b1;
                    if (last_out) begin
                        rst_c      = 1'b0;
                        out_addr_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        out_addr_d = out_addr_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Keep IDLE decodes from leaking a strobe while reset is held.
        if (!rst_n) begin
            en_G    = 1'b0;
            load_g  = 1'b0;
            err_len = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rom_addr_q <= '0;
            out_addr_q <= '0;
            info_q     <= '0;
            par_q      <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            out_addr_q <= out_addr_d;
            info_q     <= info_d;
            par_q      <= par_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign rom_addr = rom_addr_q;
    assign out_addr = out_addr_q;

endmodule

// File: tb/tb_ldpc_enc_ctrl_par.sv
// Bench for ldpc_enc_ctrl_par: vector table, codeword-level scoreboard
// with random gaps, and hand sequences for abort, long drain and async reset.
module tb_ldpc_enc_ctrl_par;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] info_beats;
    logic [7:0] par_beats;
    logic       din_valid;
    logic       din_ready;
    logic       read_parity;
    logic       parity_ready;
    logic       parity_valid;
    logic       abort;
    logic [7:0] rom_addr;
    logic [7:0] out_addr;
    logic       en_G, load_g, en_L, en_out;
    logic       done_encode, busy, rst_c, err_len;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ldpc_enc_ctrl_par #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .info_beats(info_beats), .par_beats(par_beats),
        .din_valid(din_valid), .din_ready(din_ready),
        .read_parity(read_parity), .parity_ready(parity_ready),
        .parity_valid(parity_valid), .abort(abort),
        .rom_addr(rom_addr), .out_addr(out_addr),
        .en_G(en_G), .load_g(load_g), .en_L(en_L), .en_out(en_out),
        .done_encode(done_encode), .busy(busy),
        .rst_c(rst_c), .err_len(err_len)
    );

    typedef struct {
        int st, info, par, dv, rp, pr, ab;
        int busy, drdy, enl, eng, ldg, pv, eo, dn, rc, el, rom, oa;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_in();
        start = 0; info_beats = 0; par_beats = 0; din_valid = 0;
        read_parity = 0; parity_ready = 0; abort = 0;
    endtask

    // Codeword scoreboard: expected beat indices follow from handshake counts.
    task automatic run_cw(input int info, input int par,
                          input logic [15:0] vpat, input logic [15:0] rpat,
                          input bit rnd);
        int k, j, n, hold;
        @(negedge clk);
        idle_in();
        start = 1; info_beats = 8'(info); par_beats = 8'(par);
        #1;
        chk("cw_load_g", load_g, 1);
        chk("cw_start_busy", busy, 0);
        k = 0; n = 0;
        while (k < info && n < 4000) begin
            @(negedge clk);
            idle_in();
            din_valid = rnd ? 1'($urandom_range(0, 1)) : vpat[n % 16];
            #1;
            chk("cw_din_ready", din_ready, 1);
            chk("cw_rom_addr", rom_addr, k);
            chk("cw_en_L", en_L, din_valid);
            chk("cw_en_G", en_G, din_valid);
            if (din_valid) k++;
            n++;
        end
        chk("cw_in_beats", k, info);
        hold = $urandom_range(0, 2);
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            idle_in();
            read_parity = (h == hold);
            #1;
            chk("cw_done", done_encode, 1);
            chk("cw_hold_rom", rom_addr, 0);
        end
        j = 0; n = 0;
        while (j < par && n < 4000) begin
            @(negedge clk);
            idle_in();
            parity_ready = rnd ? 1'($urandom_range(0, 1)) : rpat[n % 16];
            #1;
            chk("cw_pvalid", parity_valid, 1);
            chk("cw_out_addr", out_addr, j);
            chk("cw_en_out", en_out, parity_ready);
            chk("cw_rst_c", rst_c, (parity_ready && j == par - 1) ? 0 : 1);
            if (parity_ready) j++;
            n++;
        end
        chk("cw_out_beats", j, par);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1,0,0,0};
        tbl[1]  = '{1,0,3,0,0,0,0, 0,0,0,0,0,0,0,0,1,1,0,0};
        tbl[2]  = '{0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1,0,0,0};
        tbl[3]  = '{1,4,0,0,0,0,0, 0,0,0,0,0,0,0,0,1,1,0,0};
        tbl[4]  = '{1,4,3,1,0,0,0, 0,0,0,1,1,0,0,0,1,0,0,0};
        tbl[5]  = '{0,1,1,1,0,0,0, 1,1,1,1,0,0,0,0,1,0,0,0};
        tbl[6]  = '{0,1,1,1,0,0,0, 1,1,1,1,0,0,0,0,1,0,1,0};
        tbl[7]  = '{0,1,1,1,0,0,0, 1,1,1,1,0,0,0,0,1,0,2,0};
        tbl[8]  = '{0,1,1,1,0,0,0, 1,1,1,1,0,0,0,0,1,0,3,0};
        tbl[9]  = '{0,0,0,0,0,0,0, 1,0,0,0,0,0,0,1,1,0,0,0};
        tbl[10] = '{0,0,0,1,1,0,0, 1,0,0,0,0,0,0,1,1,0,0,0};
        tbl[11] = '{0,0,0,0,0,1,0, 1,0,0,0,0,1,1,0,1,0,0,0};
        tbl[12] = '{0,0,0,0,0,0,0, 1,0,0,0,0,1,0,0,1,0,0,1};
        tbl[13] = '{0,0,0,0,0,1,0, 1,0,0,0,0,1,1,0,1,0,0,1};
        tbl[14] = '{0,0,0,0,0,1,0, 1,0,0,0,0,1,1,0,0,0,0,2};
        tbl[15] = '{1,1,1,0,0,0,1, 0,0,0,1,1,0,0,0,1,0,0,0};
        tbl[16] = '{0,0,0,1,0,0,0, 1,1,1,1,0,0,0,0,1,0,0,0};
        tbl[17] = '{0,0,0,0,1,0,0, 1,0,0,0,0,0,0,1,1,0,0,0};
        tbl[18] = '{0,0,0,0,0,1,0, 1,0,0,0,0,1,1,0,0,0,0,0};
        tbl[19] = '{0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1,0,0,0};

        rst_n = 0;
        idle_in();
        repeat (2) @(negedge clk);
        start = 1; info_beats = 4; par_beats = 3;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_load_g", load_g, 0);
        chk("rst_en_G", en_G, 0);
        chk("rst_rst_c", rst_c, 1);
        chk("rst_rom", rom_addr, 0);
        chk("rst_out", out_addr, 0);
        @(negedge clk);
        idle_in();
        rst_n = 1;

        foreach (tbl[i]) begin
            @(negedge clk);
            start = 1'(tbl[i].st);
            info_beats = 8'(tbl[i].info);
            par_beats = 8'(tbl[i].par);
            din_valid = 1'(tbl[i].dv);
            read_parity = 1'(tbl[i].rp);
            parity_ready = 1'(tbl[i].pr);
            abort = 1'(tbl[i].ab);
            #1;
            chk($sformatf("v%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("v%0d_din_ready", i), din_ready, tbl[i].drdy);
            chk($sformatf("v%0d_en_L", i), en_L, tbl[i].enl);
            chk($sformatf("v%0d_en_G", i), en_G, tbl[i].eng);
            chk($sformatf("v%0d_load_g", i), load_g, tbl[i].ldg);
            chk($sformatf("v%0d_pvalid", i), parity_valid, tbl[i].pv);
            chk($sformatf("v%0d_en_out", i), en_out, tbl[i].eo);
            chk($sformatf("v%0d_done", i), done_encode, tbl[i].dn);
            chk($sformatf("v%0d_rst_c", i), rst_c, tbl[i].rc);
            chk($sformatf("v%0d_err_len", i), err_len, tbl[i].el);
            chk($sformatf("v%0d_rom", i), rom_addr, tbl[i].rom);
            chk($sformatf("v%0d_out", i), out_addr, tbl[i].oa);
        end

        run_cw(4, 3, 16'hFFFF, 16'h0019, 0);
        run_cw(3, 2, 16'h5555, 16'hFFFF, 0);
        run_cw(2, 255, 16'hFFFF, 16'hFFFF, 0);
        run_cw(255, 1, 16'hFFFF, 16'hFFFF, 0);
        repeat (20) run_cw($urandom_range(1, 12), $urandom_range(1, 12), 0, 0, 1);

        // Abort in ENCODE once two beats are in.
        @(negedge clk);
        idle_in(); start = 1; info_beats = 5; par_beats = 2;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            idle_in(); din_valid = 1;
            #1;
            chk("ab_enc_rom", rom_addr, b);
        end
        @(negedge clk);
        idle_in(); din_valid = 1; abort = 1;
        #1;
        chk("ab_enc_rom2", rom_addr, 2);
        chk("ab_enc_rst_c", rst_c, 0);
        chk("ab_enc_en_L", en_L, 0);
        chk("ab_enc_en_G", en_G, 0);
        @(negedge clk);
        idle_in();
        #1;
        chk("ab_enc_idle", busy, 0);
        chk("ab_enc_rom0", rom_addr, 0);
        chk("ab_enc_rst_c1", rst_c, 1);

        // Abort in OUT after one parity beat.
        @(negedge clk);
        idle_in(); start = 1; info_beats = 1; par_beats = 4;
        @(negedge clk);
        idle_in(); din_valid = 1;
        @(negedge clk);
        idle_in(); read_parity = 1;
        @(negedge clk);
        idle_in(); parity_ready = 1;
        #1;
        chk("ab_out_first", en_out, 1);
        @(negedge clk);
        idle_in(); parity_ready = 1; abort = 1;
        #1;
        chk("ab_out_addr1", out_addr, 1);
        chk("ab_out_en_out", en_out, 0);
        chk("ab_out_rst_c", rst_c, 0);
        @(negedge clk);
        idle_in();
        #1;
        chk("ab_out_idle", busy, 0);
        chk("ab_out_addr0", out_addr, 0);

        // Asynchronous reset in the middle of a drain.
        @(negedge clk);
        idle_in(); start = 1; info_beats = 2; par_beats = 4;
        repeat (2) begin
            @(negedge clk);
            idle_in(); din_valid = 1;
        end
        @(negedge clk);
        idle_in(); read_parity = 1;
        @(negedge clk);
        idle_in(); parity_ready = 1;
        @(negedge clk);
        idle_in(); parity_ready = 1;
        #1;
        chk("ar_pre_out", out_addr, 1);
        #1;
        rst_n = 0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_pvalid", parity_valid, 0);
        chk("ar_en_out", en_out, 0);
        chk("ar_rst_c", rst_c, 1);
        chk("ar_out", out_addr, 0);
        chk("ar_done", done_encode, 0);
        @(negedge clk);
        idle_in();
        rst_n = 1;
        run_cw(3, 2, 16'hFFFF, 16'hFFFF, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
